stream_fifo_buf: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 25 ++
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/stream_fifo_buf.sv | 124 ++++++++++++
 tb/tb_stream_fifo_buf.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Width helpers shared by the stream receive buffer.
// Pure elaboration-time functions; no latency, no flow control.
package stream_fifo_pkg;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one more bit than the pointer to represent "full".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // All-ones value of the given width, up to 64 bits.
    function automatic logic [63:0] sat_value(input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage with one synchronous write port and one combinational read port.
// Write lands on the rising edge; read is same-cycle; no flow control and no reset on storage.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [PTR_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [PTR_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_fifo_buf.sv
// Receive buffer for a non-stallable source, re-emitted over valid/ready with a registered FWFT head.
// One-edge write-to-output latency; when full and not popping, incoming words are dropped and counted.
module stream_fifo_buf
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 12,
    parameter int DROP_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid_i,
    input  logic [DATA_W-1:0]              in_data_i,
    input  logic                           out_ready_i,
    input  logic                           clr_ovf_i,
    output logic                           out_valid_o,
    output logic [DATA_W-1:0]              out_data_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           almost_full_o,
    output logic                           ovf_o,
    output logic [DROP_W-1:0]              drop_cnt_o
);

    localparam int                PTR_W     = ptr_width(DEPTH);
    localparam int                CNT_W     = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(AFULL_TH);
    localparam logic [DROP_W-1:0] DROP_SAT  = DROP_W'(sat_value(DROP_W));

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  remain;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              full, push, pop, drop;
    logic [DATA_W-1:0] rd_data;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data_i),
        .rd_addr_i (rd_ptr_d),
        .rd_data_o (rd_data)
    );

    // A push while full is only legal because the popped slot frees up this same edge.
    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = out_valid_q && out_ready_i;
        push     = in_valid_i && (!full || pop);
        drop     = in_valid_i && !push;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        remain   = pop  ? count_q - CNT_W'(1)  : count_q;
        count_d  = push ? remain + CNT_W'(1)   : remain;
    end

    // Head is reloaded from the new read pointer every edge; if the FIFO would
    // otherwise be empty the incoming word bypasses straight into the head.
    always_comb begin
        out_valid_d = (count_d != '0);
        out_data_d  = out_data_q;
        if (remain != '0) begin
            out_data_d = rd_data;
        end else if (push) begin
            out_data_d = in_data_i;
        end
    end

    always_comb begin
        afull_d = (count_d >= AFULL_CNT);
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (clr_ovf_i) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != DROP_SAT) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            afull_q     <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            afull_q     <= afull_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign count_o       = count_q;
    assign almost_full_o = afull_q;
    assign ovf_o         = ovf_q;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_stream_fifo_buf.sv
// Directed and randomized checks of stream_fifo_buf against a queue-based reference model.
module tb_stream_fifo_buf;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        count;
    logic              almost_full;
    logic              ovf;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mq[$];
    int                m_drop = 0;
    bit                m_ovf = 1'b0;
    logic [DATA_W-1:0] m_out = '0;

    stream_fifo_buf #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH),
        .DROP_W   (DROP_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .out_ready_i   (out_ready),
        .clr_ovf_i     (clr_ovf),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .count_o       (count),
        .almost_full_o (almost_full),
        .ovf_o         (ovf),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"},   64'(out_valid),   64'(mq.size() != 0));
        chk({tag, ".out_data"},    64'(out_data),    64'(m_out));
        chk({tag, ".count"},       64'(count),       64'(mq.size()));
        chk({tag, ".almost_full"}, 64'(almost_full), 64'(mq.size() >= AFULL_TH));
        chk({tag, ".ovf"},         64'(ovf),         64'(m_ovf));
        chk({tag, ".drop_cnt"},    64'(drop_cnt),    64'(m_drop));
    endtask

    task automatic model_reset();
        mq.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        m_out  = '0;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, compare.
    task automatic step(input string tag, input bit v, input logic [DATA_W-1:0] d,
                        input bit rdy, input bit clr);
        bit pop, push;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
        pop  = (mq.size() != 0) && rdy;
        push = v && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end else if (v && !push) begin
            m_ovf = 1'b1;
            if (m_drop < DROP_MAX) m_drop++;
        end
        if (mq.size() != 0) m_out = mq[0];
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single word passes through with one cycle of out_valid
        step("t1_write", 1'b1, 8'hA5, 1'b1, 1'b0);
        chk("t1_head", 64'(out_data), 64'hA5);
        step("t1_read", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_empty", 64'(count), 64'd0);

        // 2: fill to full
        for (int i = 0; i < DEPTH; i++) step("t2_fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("t2_full", 64'(count), 64'(DEPTH));

        // 3: drops while full, then clear
        for (int i = 0; i < 3; i++) step("t3_drop", 1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
        chk("t3_drops", 64'(drop_cnt), 64'd3);
        step("t3_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // 4: full with simultaneous push/pop
        for (int i = 0; i < 20; i++) step("t4_stream", 1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("t4_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) step("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // 5: saturation and clear-vs-drop priority
        for (int i = 0; i < DEPTH; i++) step("t5_fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step("t5_drop", 1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("t5_sat", 64'(drop_cnt), 64'hFF);
        step("t5_clr_drop", 1'b1, 8'h77, 1'b0, 1'b1);
        chk("t5_clr_zero", 64'(drop_cnt), 64'd0);

        // random traffic, occasional clears
        for (int i = 0; i < 800; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), 8'($urandom),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
        end

        // 6: asynchronous reset with 7 entries present
        for (int i = 0; i < DEPTH + 1; i++) step("t6_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("t6_fill", 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        chk("t6_pre", 64'(count), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_write", 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("t6_first", 64'(out_data), 64'h3C);
        step("t6_read", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
